somador_serial: RTL
===================

Name: somador_serial

Overview:
- Parametrised bit-serial adder, LSB first: one full-adder bit per clock, carry held in a flip-flop.
- Successor to the combinational half-adder: adds two LARGURA-bit operands plus carry-in over LARGURA cycles.
- Uses a start/busy/done handshake.
- Building block for area-constrained arithmetic paths in the arithmetic-operators library.

Parameters:
- LARGURA, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  LARGURA  operand A; captured on the accepting edge.
- B  input  LARGURA  operand B; captured on the accepting edge.
- CIN  input  1  carry-in; captured on the accepting edge.
- S  output  LARGURA  registered sum; held until the next completion.
- C  output  1  registered carry-out; held until the next completion.
- busy  output  1  high while an operation is in progress (SOMA or FIM).
- done  output  1  one-cycle pulse; S and C are valid and newly updated.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; S=0, C=0, busy=0, done=0; shift registers, carry flop and bit counter cleared.
- Reset mid-operation aborts immediately. No done pulse is issued. S and C return to 0.
- Internal regs:
  - ra, rb: LARGURA-bit operand shift regs.
  - rs: LARGURA-bit sum shift reg.
  - cy: carry flop.
  - cnt: bit counter, width max(1, clog2(LARGURA)).
- IDLE, start=1 at an edge:
  - ra<=A, rb<=B, cy<=CIN, cnt<=0.
  - Go to SOMA.
- IDLE, start=0: remain in IDLE.
- SOMA, every edge:
  - Bit result: sum = ra[0]^rb[0]^cy; carry = majority(ra[0], rb[0], cy).
  - ra and rb shift right by one (MSB filled with 0).
  - rs shifts right, with sum inserted at the MSB.
  - cy<=carry, cnt<=cnt+1.
  - On the edge where cnt==LARGURA-1: load S with the final shifted rs value, load C with carry, go to FIM.
- FIM: done=1 for exactly this one cycle; next edge returns to IDLE.
- busy is combinational from state: 1 in SOMA and FIM, 0 in IDLE.
- done is combinational from state: 1 only in FIM.
- Latency: start sampled at edge k → S/C updated and done high from edge k+LARGURA to edge k+LARGURA+1. Next start is accepted at edge k+LARGURA+1 at the earliest.
- start while busy is ignored. No queuing, no effect on the operation in flight.
- Operand changes on A, B, CIN after the accepting edge have no effect.
- LARGURA=1: SOMA lasts one cycle (cnt==0 is terminal); done at edge k+1.
- Arithmetic: {C,S} = A + B + CIN, modulo 2^(LARGURA+1). Exact; no saturation.
- Wrap: all-ones + 1 gives S=0, C=1.

Optional Feature:
- Macro: SOMADOR_SERIAL_SUB_EN
- When defined, port SUB (input, 1) is added.
- SUB is captured on the accepting edge with the operands.
- SUB=1 selects subtraction:
  - rb loads ~B.
  - cy loads 1, and CIN is ignored.
  - Result S = A − B mod 2^LARGURA.
  - C=1 means no borrow (A≥B unsigned); C=0 means borrow.
- SUB=0: behaviour identical to addition.
- When not defined: no SUB port, addition only, no extra logic.

Test Plan:
- Reset: rst_n=0 for 3 cycles with start=1 → S=0, C=0, busy=0, done=0 throughout; no operation starts until rst_n=1.
- Basic add, LARGURA=8: A=8'h0F, B=8'h01, CIN=0, start pulse at edge k → busy=1 from k; done=1 exactly at k+8..k+9; S=8'h10, C=0.
- Wrap and carry-in: A=8'hFF, B=8'h01, CIN=0 → S=8'h00, C=1. Then A=8'hFF, B=8'hFF, CIN=1 → S=8'hFF, C=1; S/C hold between operations.
- Handshake: start held high continuously with A=8'h03, B=8'h04 → back-to-back results S=8'h07 every 9 cycles; inputs changed mid-operation do not alter the result; done never wider than 1 cycle.
- Abort: rst_n pulsed low at cycle 4 of an operation → outputs 0 immediately, no done; following operation A=8'h20, B=8'h22 gives S=8'h42, C=0.
- SOMADOR_SERIAL_SUB_EN, SUB=1:
  - A=8'h05, B=8'h07 → S=8'hFE, C=0.
  - A=8'h07, B=8'h05 → S=8'h02, C=1.
  - LARGURA=1 instance, A=1, B=1, SUB=0 → done after 1 cycle, S=0, C=1.

Source files
------------

// File: rtl/somador_serial.sv
// somador_serial
//   Bit-serial adder, LSB first. One full-adder bit is evaluated per clock
//   and the carry between bits lives in a flip-flop, so a LARGURA-bit sum
//   takes LARGURA cycles in SOMA followed by one FIM cycle carrying done.
//
// Optional feature (macro SOMADOR_SERIAL_SUB_EN):
//   adds input SUB; SUB=1 computes A - B through A + ~B + 1, CIN is ignored,
//   and C reads as "no borrow" (1 when A >= B unsigned).
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   A, B   in   LARGURA-bit operands, captured on the accepting edge
//   CIN    in   carry-in, captured on the accepting edge
//   SUB    in   (only with SOMADOR_SERIAL_SUB_EN) subtract select
//   S      out  registered sum, held until the next completion
//   C      out  registered carry-out, held until the next completion
//   busy   out  high in SOMA and FIM
//   done   out  one-cycle pulse in FIM; S and C freshly updated
module somador_serial #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               CIN,
`ifdef SOMADOR_SERIAL_SUB_EN
  input  logic               SUB,
`endif
  output logic [LARGURA-1:0] S,
  output logic               C,
  output logic               busy,
  output logic               done
);

  // Counter only needs to reach LARGURA-1; keep at least one bit for LARGURA=1.
  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] LAST = CW'(LARGURA - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOMA = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [LARGURA-1:0] ra, rb, rs;
  logic [LARGURA-1:0] rs_next, rb_load;
  logic [LARGURA:0]   rs_ext;
  logic [CW-1:0]      cnt;
  logic               cy, cy_load;
  logic               sum_bit, carry_bit, last_bit;

  // Operand preparation at the accepting edge. Subtraction reuses the adder
  // by inverting B and forcing the initial carry to 1.
`ifdef SOMADOR_SERIAL_SUB_EN
  assign rb_load = SUB ? ~B : B;
  assign cy_load = SUB ? 1'b1 : CIN;
`else
  assign rb_load = B;
  assign cy_load = CIN;
`endif

  // One full-adder slice on the current LSBs.
  assign sum_bit   = ra[0] ^ rb[0] ^ cy;
  assign carry_bit = (ra[0] & rb[0]) | (ra[0] & cy) | (rb[0] & cy);
  assign last_bit  = (cnt == LAST);

  // New sum bit enters at the MSB; after LARGURA shifts bit 0 of the operands
  // has walked down to rs[0]. Concatenate-then-shift keeps this legal for
  // LARGURA=1 where rs[LARGURA-1:1] would be an empty slice.
  assign rs_ext  = {sum_bit, rs} >> 1;
  assign rs_next = rs_ext[LARGURA-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SOMA;
      SOMA:    if (last_bit) state_next = FIM;
      FIM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIM);

  // Datapath: capture in IDLE, shift one bit per SOMA cycle, publish S/C on
  // the last bit. S/C are untouched elsewhere so they hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      rs  <= '0;
      cy  <= 1'b0;
      cnt <= '0;
      S   <= '0;
      C   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= A;
            rb  <= rb_load;
            cy  <= cy_load;
            cnt <= '0;
          end
        end
        SOMA: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_next;
          cy  <= carry_bit;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            S <= rs_next;
            C <= carry_bit;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
